// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_IMM   = 2'd2
  } state_t;

  localparam int RESET_VEC_DEFAULT = 0;
  localparam int IMM_BIT_DEFAULT   = 0;
  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port, hazard/branch inputs and IF/ID outputs of the fetch stage.
interface fetch_if #(parameter int ADDR_W = 16) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [15:0]       instr_out;
  logic [15:0]       imm_out;
  logic [ADDR_W-1:0] pc_next_out;
  logic              valid_out;

  modport master (
    output imem_addr, instr_out, imm_out, pc_next_out, valid_out,
    input  imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, instr_out, imm_out, pc_next_out, valid_out,
    output imem_data, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_predecode.sv
// Opcode-word classification; currently only separates single- from two-word instructions.
module fetch_predecode (
  input  logic imm_flag,
  output logic is_two_word
);

  assign is_two_word = imm_flag;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: boots PC from memory, assembles two-word instructions, drives IF/ID.
//   state    | meaning
//   ST_BOOT  | reading the reset vector word to load the PC
//   ST_FETCH | reading an opcode word at pc
//   ST_IMM   | opcode held in hold_reg, reading its immediate word at pc
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int RESET_VEC_ADDR = RESET_VEC_DEFAULT,
  parameter int IMM_BIT        = IMM_BIT_DEFAULT
) (
  input logic   clk,
  input logic   rst_n,
  fetch_if.master bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
  logic [15:0]       hold_reg, hold_nxt;
  logic [15:0]       instr_q, instr_nxt;
  logic [15:0]       imm_q, imm_nxt;
  logic [ADDR_W-1:0] pc_next_q, pc_next_nxt;
  logic              valid_q, valid_nxt;
  logic              is_two_word;

  fetch_predecode u_predecode (
    .imm_flag    (bus.imem_data[IMM_BIT]),
    .is_two_word (is_two_word)
  );

  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      pc        <= '0;
      hold_reg  <= NOP_WORD;
      instr_q   <= NOP_WORD;
      imm_q     <= NOP_WORD;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      hold_reg  <= hold_nxt;
      instr_q   <= instr_nxt;
      imm_q     <= imm_nxt;
      pc_next_q <= pc_next_nxt;
      valid_q   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    hold_nxt    = hold_reg;
    instr_nxt   = instr_q;
    imm_nxt     = imm_q;
    pc_next_nxt = pc_next_q;
    valid_nxt   = valid_q;
    unique case (state)
      ST_BOOT: begin
        pc_nxt    = ADDR_W'(bus.imem_data);
        state_nxt = ST_FETCH;
        valid_nxt = 1'b0;
      end
      ST_FETCH: begin
        // A redirect must win over a stall so it is not lost while frozen.
        if (bus.branch_taken) begin
          pc_nxt    = bus.branch_target;
          valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          pc_nxt = pc_inc;
          if (is_two_word) begin
            hold_nxt  = bus.imem_data;
            valid_nxt = 1'b0;
            state_nxt = ST_IMM;
          end else begin
            instr_nxt   = bus.imem_data;
            imm_nxt     = NOP_WORD;
            pc_next_nxt = pc_inc;
            valid_nxt   = 1'b1;
          end
        end
      end
      ST_IMM: begin
        if (bus.branch_taken) begin
          pc_nxt    = bus.branch_target;
          valid_nxt = 1'b0;
          state_nxt = ST_FETCH;
        end else if (!bus.stall) begin
          instr_nxt   = hold_reg;
          imm_nxt     = bus.imem_data;
          pc_next_nxt = pc_inc;
          valid_nxt   = 1'b1;
          pc_nxt      = pc_inc;
          state_nxt   = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign bus.imem_addr   = (state == ST_BOOT) ? ADDR_W'(RESET_VEC_ADDR) : pc;
  assign bus.instr_out   = instr_q;
  assign bus.imm_out     = imm_q;
  assign bus.pc_next_out = pc_next_q;
  assign bus.valid_out   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch-unit bench: directed scenarios plus random stall/branch/reset traffic against a reference model.
module tb_fetch_unit;

  localparam int          AW    = 16;
  localparam logic [15:0] RVEC  = 16'h0000;
  localparam int          IMMB  = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] mem [0:65535];

  fetch_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .RESET_VEC_ADDR(0), .IMM_BIT(IMMB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: fetch pointer, pending opcode words, last delivered instruction.
  bit          m_booted;
  logic [15:0] m_pc;
  logic [15:0] m_part [$];
  logic [15:0] e_instr, e_imm, e_pcn;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = '0;
    m_part.delete();
    e_instr  = '0;
    e_imm    = '0;
    e_pcn    = '0;
    e_valid  = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [15:0] t);
    logic [15:0] w;
    if (!m_booted) begin
      m_pc     = mem[RVEC];
      m_booted = 1'b1;
      e_valid  = 1'b0;
    end else if (b) begin
      m_pc = t;
      m_part.delete();
      e_valid = 1'b0;
    end else if (s) begin
      // frozen
    end else if (m_part.size() == 0) begin
      w = mem[m_pc];
      m_pc = m_pc + 16'd1;
      if (w[IMMB]) begin
        m_part.push_back(w);
        e_valid = 1'b0;
      end else begin
        e_instr = w;
        e_imm   = '0;
        e_pcn   = m_pc;
        e_valid = 1'b1;
      end
    end else begin
      e_instr = m_part.pop_front();
      e_imm   = mem[m_pc];
      m_pc    = m_pc + 16'd1;
      e_pcn   = m_pc;
      e_valid = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   32'(bus.imem_addr),   32'(m_booted ? m_pc : RVEC));
    chk("instr_out",   32'(bus.instr_out),   32'(e_instr));
    chk("imm_out",     32'(bus.imm_out),     32'(e_imm));
    chk("pc_next_out", 32'(bus.pc_next_out), 32'(e_pcn));
    chk("valid_out",   32'(bus.valid_out),   32'(e_valid));
  endtask

  task automatic cycle(input bit s, input bit b, input logic [15:0] t);
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    @(posedge clk);
    model_step(s, b, t);
    #1;
    check_all();
  endtask

  // Called between edges so the async clear is observed before any clock.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0010;
    mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'h0801;
    mem[16'h0012] = 16'hBEEF;
    mem[16'h0013] = 16'h0002;
    mem[16'h0040] = 16'h4444;
    mem[16'h0041] = 16'h0003;
    mem[16'h0042] = 16'hBEEF;
    mem[16'h0050] = 16'h5554;
    mem[16'h0060] = 16'h6666;
    rst_n = 1'b1;
    #2;
    do_reset();

    // boot then first single-word instruction
    cycle(0, 0, 0);
    chk("boot_bubble", 32'(bus.valid_out), 32'd0);
    cycle(0, 0, 0);
    chk("boot_instr", 32'(bus.instr_out), 32'h1234);
    chk("boot_pcn",   32'(bus.pc_next_out), 32'h0011);
    chk("boot_valid", 32'(bus.valid_out), 32'd1);
    // two-word: one bubble then the assembled pair
    cycle(0, 0, 0);
    chk("tw_bubble", 32'(bus.valid_out), 32'd0);
    cycle(0, 0, 0);
    chk("tw_instr", 32'(bus.instr_out), 32'h0801);
    chk("tw_imm",   32'(bus.imm_out), 32'hBEEF);
    chk("tw_pcn",   32'(bus.pc_next_out), 32'h0013);
    // branch from FETCH
    cycle(0, 1, 16'h0040);
    chk("br_valid", 32'(bus.valid_out), 32'd0);
    chk("br_addr",  32'(bus.imem_addr), 32'h0040);
    cycle(0, 0, 0);
    chk("br_instr", 32'(bus.instr_out), 32'h4444);
    // branch while in IMM abandons the partial instruction
    cycle(0, 0, 0);
    cycle(0, 1, 16'h0050);
    chk("brimm_addr", 32'(bus.imem_addr), 32'h0050);
    chk("brimm_valid", 32'(bus.valid_out), 32'd0);
    cycle(0, 0, 0);
    chk("brimm_next", 32'(bus.instr_out), 32'h5554);
    // stall holds everything, then stall+branch still redirects
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      chk("stall_addr", 32'(bus.imem_addr), 32'h0051);
      chk("stall_instr", 32'(bus.instr_out), 32'h5554);
    end
    cycle(1, 1, 16'h0060);
    chk("stallbr_addr", 32'(bus.imem_addr), 32'h0060);
    cycle(0, 0, 0);
    chk("stallbr_instr", 32'(bus.instr_out), 32'h6666);

    // PC wrap between opcode and immediate, then async reset during IMM
    mem[16'h0000] = 16'hFFFF;
    mem[16'hFFFF] = 16'h0101;
    mem[16'h0001] = 16'h0007;
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h0000);
    cycle(0, 0, 0);
    chk("wrap_imm", 32'(bus.imm_out), 32'hFFFF);
    chk("wrap_pcn", 32'(bus.pc_next_out), 32'h0001);
    cycle(0, 0, 0);
    chk("imm_pending", 32'(bus.imem_addr), 32'h0002);
    do_reset();
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_instr", 32'(bus.instr_out), 32'd0);

    // random traffic
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage; it is the consumer of Execute's branch decision (branch_output and target).
- Boots the PC from a reset vector held in instruction memory.
- Fetches one 16-bit word per cycle and assembles two-word immediate instructions (opcode word + immediate word).
- Drives the IF/ID pipeline register with instruction, immediate, next-PC and valid.
- Honours hazard stalls and redirects on taken branches by inserting a bubble.

Parameters:
- ADDR_W, 16, instruction-memory address / PC width.
- RESET_VEC_ADDR, 0, memory word holding the boot PC.
- IMM_BIT, 0, opcode-word bit; 1 = an immediate word follows.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous reset, active low.
- imem_addr  out  ADDR_W  instruction-memory read address (combinational read).
- imem_data  in  16  word at imem_addr, same cycle.
- stall  in  1  hazard unit: freeze PC, state and all outputs.
- branch_taken  in  1  Execute branch_output: redirect fetch.
- branch_target  in  ADDR_W  redirect address, valid when branch_taken=1.
- instr_out  out  16  opcode word to IF/ID.
- imm_out  out  16  immediate word; 0 for single-word instructions.
- pc_next_out  out  ADDR_W  address following the delivered instruction (call return address).
- valid_out  out  1  IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (async, rst_n=0) forces:
  - pc=0, state=BOOT, hold_reg=0.
  - instr_out=0, imm_out=0, pc_next_out=0, valid_out=0.
  - Reset mid-operation discards any held opcode word. Operation restarts from BOOT on the first posedge after rst_n rises.
- States: BOOT, FETCH, IMM.
- BOOT:
  - imem_addr=RESET_VEC_ADDR.
  - At the edge: pc<=imem_data[ADDR_W-1:0], state<=FETCH, valid_out<=0.
  - stall and branch_taken are ignored in BOOT.
- FETCH (imem_addr=pc). Priority at each edge: branch_taken > stall > normal.
  - branch_taken: pc<=branch_target, valid_out<=0. instr_out, imm_out and pc_next_out hold. state stays FETCH.
  - stall: everything holds, including valid_out.
  - normal, imem_data[IMM_BIT]=0: instr_out<=imem_data, imm_out<=0, pc_next_out<=pc+1, valid_out<=1, pc<=pc+1.
  - normal, imem_data[IMM_BIT]=1: hold_reg<=imem_data, pc<=pc+1, valid_out<=0, state<=IMM.
- IMM (imem_addr=pc, pointing at the immediate word):
  - branch_taken: the partial instruction is abandoned. pc<=branch_target, valid_out<=0, state<=FETCH.
  - stall: everything holds; hold_reg is preserved.
  - normal: instr_out<=hold_reg, imm_out<=imem_data, pc_next_out<=pc+1, valid_out<=1, pc<=pc+1, state<=FETCH.
- Latency:
  - Single-word instruction appears on the outputs 1 cycle after its address is on imem_addr.
  - Two-word instruction appears 2 cycles after its opcode address; exactly one bubble precedes it.
  - First valid instruction appears 2 cycles after reset release (BOOT + FETCH).
- Width and arithmetic:
  - pc+1 is modulo 2^ADDR_W: 0xFFFF wraps to 0x0000, including between the opcode and immediate words.
  - branch_target is taken verbatim.
- Branch and stall asserted together: the branch wins, because the redirect must not be lost while the hazard unit stalls.
- Outputs are registered. imem_addr is a combinational function of state and pc only, never of stall or branch inputs.

Decomposition:
- Shared package fetch_pkg:
  - state enum {BOOT, FETCH, IMM}.
  - RESET_VEC_ADDR and IMM_BIT defaults.
  - NOP word 16'h0000.
- One sub-module, fetch_predecode: combinational; from imem_data[IMM_BIT], produces is_two_word. It leaves room for future opcode classes.

Test Plan:
- Boot: M[0]=0x0010, M[0x10]=0x1234 (single word), release rst_n → after 2 cycles instr_out=0x1234, imm_out=0, pc_next_out=0x0011, valid_out=1.
- Two-word: M[0x10]=0x0801 (IMM_BIT set), M[0x11]=0xBEEF → one bubble (valid_out=0), then instr_out=0x0801, imm_out=0xBEEF, pc_next_out=0x0012, valid_out=1.
- Branch: in FETCH at pc=0x0012, pulse branch_taken with branch_target=0x0040 → next cycle valid_out=0, imem_addr=0x0040; following cycle delivers M[0x40].
- Branch during IMM: branch_taken=1, target 0x0050 while pc=0x0011 in IMM → no instruction with imm 0xBEEF is ever emitted; state FETCH, imem_addr=0x0050.
- Stall: hold stall=1 for 3 cycles mid-stream → all outputs and imem_addr frozen. stall+branch_taken together → redirect still taken.
- Wrap and reset: boot PC=0xFFFF with a two-word instruction → immediate read from 0x0000, pc_next_out=0x0001. Assert rst_n=0 during IMM → outputs 0 immediately (asynchronously), restart from BOOT.
